// File: rtl/column_plot_responder.sv
// Per-column pixel store for the plotter: a 4-phase write handshake into a
// private column memory, a clear sweep, and an independent two-stage scanout read port.
module column_plot_responder #(
    parameter int N_ROWS  = 480,
    parameter int ROW_W   = 10,
    parameter int COLOR_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               col_select,
    input  logic [ROW_W-1:0]   row_select,
    input  logic [COLOR_W-1:0] pixel_color,
    output logic               return_sig,
    input  logic               clear_req,
    output logic               clear_done,
    input  logic               vga_read_en,
    input  logic [ROW_W-1:0]   vga_row,
    output logic [COLOR_W-1:0] vga_pixel,
    output logic               vga_valid,
    output logic               oob_err,
    output logic [15:0]        write_count
);

    localparam logic [ROW_W:0]   ROW_LIMIT = (ROW_W+1)'(N_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(N_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_DROP,
        S_CLEAR
    } state_t;

    state_t             state_reg, state_next;
    logic [ROW_W-1:0]   sweep_reg, sweep_next;
    logic               pending_reg, pending_next;
    logic               return_reg, return_next;
    logic               clear_done_reg, clear_done_next;
    logic               oob_reg, oob_next;
    logic [15:0]        count_reg, count_next;

    logic               mem_we;
    logic [ROW_W-1:0]   mem_waddr;
    logic [COLOR_W-1:0] mem_wdata;
    logic [COLOR_W-1:0] mem [N_ROWS];

    logic               row_in_range;
    logic               vga_in_range;

    assign row_in_range = ({1'b0, row_select} < ROW_LIMIT);
    assign vga_in_range = ({1'b0, vga_row} < ROW_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            sweep_reg      <= '0;
            pending_reg    <= 1'b0;
            return_reg     <= 1'b0;
            clear_done_reg <= 1'b0;
            oob_reg        <= 1'b0;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            sweep_reg      <= sweep_next;
            pending_reg    <= pending_next;
            return_reg     <= return_next;
            clear_done_reg <= clear_done_next;
            oob_reg        <= oob_next;
            count_reg      <= count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sweep_next      = sweep_reg;
        pending_next    = pending_reg | clear_req;
        return_next     = return_reg;
        clear_done_next = 1'b0;
        oob_next        = oob_reg;
        count_next      = count_reg;
        mem_we          = 1'b0;
        mem_waddr       = row_select;
        mem_wdata       = pixel_color;

        case (state_reg)
            S_IDLE: begin
                // A pending or fresh clear wins over a plot request in the same cycle.
                if (pending_reg || clear_req) begin
                    state_next   = S_CLEAR;
                    sweep_next   = '0;
                    pending_next = 1'b0;
                end else if (col_select) begin
                    state_next = S_ACK;
                    if (row_in_range) begin
                        mem_we     = 1'b1;
                        count_next = count_reg + 16'd1;
                    end else begin
                        oob_next = 1'b1;
                    end
                end
            end
            S_ACK: begin
                return_next = 1'b1;
                state_next  = S_DROP;
            end
            S_DROP: begin
                if (!col_select) begin
                    return_next = 1'b0;
                    state_next  = S_IDLE;
                end
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_reg;
                mem_wdata = '0;
                if (sweep_reg == LAST_ROW) begin
                    clear_done_next = 1'b1;
                    state_next      = S_IDLE;
                end else begin
                    sweep_next = sweep_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Memory is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic               rd_en_reg;
    logic [ROW_W-1:0]   rd_addr_reg;
    logic               rd_oob_reg;
    logic               vga_valid_reg;
    logic [COLOR_W-1:0] vga_pixel_reg;

    // Stage 1 captures the address; stage 2 reads the array, so a write on
    // the same edge is seen as old data.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            rd_oob_reg    <= 1'b0;
            vga_valid_reg <= 1'b0;
            vga_pixel_reg <= '0;
        end else begin
            rd_en_reg     <= vga_read_en;
            vga_valid_reg <= rd_en_reg;
            if (vga_read_en) begin
                rd_addr_reg <= vga_in_range ? vga_row : '0;
                rd_oob_reg  <= !vga_in_range;
            end
            if (rd_en_reg) begin
                vga_pixel_reg <= rd_oob_reg ? '0 : mem[rd_addr_reg];
            end
        end
    end

    assign return_sig  = return_reg;
    assign clear_done  = clear_done_reg;
    assign oob_err     = oob_reg;
    assign write_count = count_reg;
    assign vga_valid   = vga_valid_reg;
    assign vga_pixel   = vga_pixel_reg;

endmodule

// File: tb/tb_column_plot_responder.sv
// Randomized bench for column_plot_responder with a behavioural column model
// (array of pixels plus expected counters) driven from one initial block.
module tb_column_plot_responder;

    localparam int N_ROWS  = 480;
    localparam int ROW_W   = 10;
    localparam int COLOR_W = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic               col_select;
    logic [ROW_W-1:0]   row_select;
    logic [COLOR_W-1:0] pixel_color;
    logic               return_sig;
    logic               clear_req;
    logic               clear_done;
    logic               vga_read_en;
    logic [ROW_W-1:0]   vga_row;
    logic [COLOR_W-1:0] vga_pixel;
    logic               vga_valid;
    logic               oob_err;
    logic [15:0]        write_count;

    column_plot_responder #(
        .N_ROWS (N_ROWS),
        .ROW_W  (ROW_W),
        .COLOR_W(COLOR_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .col_select (col_select),
        .row_select (row_select),
        .pixel_color(pixel_color),
        .return_sig (return_sig),
        .clear_req  (clear_req),
        .clear_done (clear_done),
        .vga_read_en(vga_read_en),
        .vga_row    (vga_row),
        .vga_pixel  (vga_pixel),
        .vga_valid  (vga_valid),
        .oob_err    (oob_err),
        .write_count(write_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  model_mem [N_ROWS];
    logic [15:0] exp_count;
    logic        exp_oob;

    function automatic logic [7:0] model_read(input int row);
        return (row < N_ROWS) ? model_mem[row] : 8'h00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N_ROWS; i++) model_mem[i] = 8'h00;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full 4-phase handshake; reports the ack latency in cycles and the hold/fall behaviour.
    task automatic plot(input int row, input logic [7:0] color, input int extra,
                        output int rise_lat, output bit held_ok, output bit fall_ok);
        logic [ROW_W-1:0] r;
        r = row[ROW_W-1:0];
        col_select  = 1'b1;
        row_select  = r;
        pixel_color = color;
        rise_lat = -1;
        held_ok  = 1'b1;
        fall_ok  = 1'b0;
        for (int n = 1; n <= 2000; n++) begin
            step();
            if (return_sig === 1'b1) begin
                rise_lat = n;
                break;
            end
        end
        if (rise_lat >= 0) begin
            if (row < N_ROWS) begin
                model_mem[row] = color;
                exp_count = exp_count + 16'd1;
            end else begin
                exp_oob = 1'b1;
            end
            for (int k = 0; k < extra; k++) begin
                step();
                if (return_sig !== 1'b1) held_ok = 1'b0;
            end
        end
        col_select = 1'b0;
        step();
        fall_ok = (return_sig === 1'b0);
    endtask

    task automatic read_row(input int row, output logic [7:0] data, output bit timing_ok);
        logic v1;
        vga_read_en = 1'b1;
        vga_row     = row[ROW_W-1:0];
        step();
        vga_read_en = 1'b0;
        v1 = vga_valid;
        step();
        timing_ok = (v1 === 1'b0) && (vga_valid === 1'b1);
        data = vga_pixel;
    endtask

    task automatic test_reset();
        reset = 1'b1; col_select = 1'b0; row_select = '0; pixel_color = '0;
        clear_req = 1'b0; vga_read_en = 1'b0; vga_row = '0;
        repeat (3) step();
        checks++; if (return_sig !== 1'b0) begin failures++; $display("FAIL reset_return_sig got=%b exp=0", return_sig); end
        checks++; if (clear_done !== 1'b0) begin failures++; $display("FAIL reset_clear_done got=%b exp=0", clear_done); end
        checks++; if (vga_valid !== 1'b0) begin failures++; $display("FAIL reset_vga_valid got=%b exp=0", vga_valid); end
        checks++; if (vga_pixel !== 8'h00) begin failures++; $display("FAIL reset_vga_pixel got=%h exp=00", vga_pixel); end
        checks++; if (oob_err !== 1'b0) begin failures++; $display("FAIL reset_oob_err got=%b exp=0", oob_err); end
        checks++; if (write_count !== 16'd0) begin failures++; $display("FAIL reset_write_count got=%0d exp=0", write_count); end
        reset = 1'b0;
        exp_count = 16'd0;
        exp_oob   = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_clear();
        int rl; bit h, f; int bad_ack, n, bad_rows, ret_high;
        logic [7:0] d; bit t;
        bad_ack = 0;
        for (int r = 0; r < N_ROWS; r++) begin
            plot(r, 8'hAA, 0, rl, h, f);
            if (rl != 2 || !f) bad_ack++;
        end
        checks++; if (bad_ack != 0) begin failures++; $display("FAIL fill_handshakes bad=%0d exp=0", bad_ack); end
        checks++; if (write_count !== exp_count) begin failures++; $display("FAIL fill_write_count got=%0d exp=%0d", write_count, exp_count); end
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n = -1; ret_high = 0;
        for (int k = 1; k <= 2000; k++) begin
            step();
            if (return_sig !== 1'b0) ret_high++;
            if (clear_done === 1'b1) begin n = k; break; end
        end
        checks++; if (n != N_ROWS) begin failures++; $display("FAIL clear_latency got=%0d exp=%0d", n, N_ROWS); end
        checks++; if (ret_high != 0) begin failures++; $display("FAIL clear_return_sig high_cycles=%0d exp=0", ret_high); end
        step();
        checks++; if (clear_done !== 1'b0) begin failures++; $display("FAIL clear_done_width got=%b exp=0", clear_done); end
        model_clear();
        bad_rows = 0;
        for (int r = 0; r < N_ROWS; r++) begin
            read_row(r, d, t);
            if (!t || d !== model_read(r)) bad_rows++;
        end
        checks++; if (bad_rows != 0) begin failures++; $display("FAIL clear_readback bad_rows=%0d exp=0", bad_rows); end
        $display("test_clear latency=%0d", n);
    endtask

    task automatic test_write_handshake();
        int rl; bit h, f; logic [7:0] d; bit t;
        plot(5, 8'hFF, 0, rl, h, f);
        checks++; if (rl != 2) begin failures++; $display("FAIL hs_rise_latency got=%0d exp=2", rl); end
        checks++; if (!f) begin failures++; $display("FAIL hs_fall got=%b exp=0", return_sig); end
        read_row(5, d, t);
        checks++; if (!t || d !== 8'hFF) begin failures++; $display("FAIL hs_readback got=%h timing=%b exp=ff", d, t); end
        checks++; if (write_count !== exp_count) begin failures++; $display("FAIL hs_write_count got=%0d exp=%0d", write_count, exp_count); end
        $display("test_write_handshake row=5 data=%h count=%0d", d, write_count);
    endtask

    task automatic test_slow_plotter();
        int rl; bit h, f;
        plot(7, 8'h12, 10, rl, h, f);
        checks++; if (rl != 2) begin failures++; $display("FAIL slow_rise_latency got=%0d exp=2", rl); end
        checks++; if (!h) begin failures++; $display("FAIL slow_hold return_sig dropped exp=held"); end
        checks++; if (!f) begin failures++; $display("FAIL slow_fall got=%b exp=0", return_sig); end
        checks++; if (write_count !== exp_count) begin failures++; $display("FAIL slow_write_count got=%0d exp=%0d", write_count, exp_count); end
        $display("test_slow_plotter count=%0d", write_count);
    endtask

    task automatic test_out_of_range();
        int rl; bit h, f; logic [7:0] d; bit t;
        plot(500, 8'h3C, 1, rl, h, f);
        checks++; if (rl != 2 || !f) begin failures++; $display("FAIL oob_handshake rise=%0d fall=%b exp=2/1", rl, f); end
        checks++; if (oob_err !== 1'b1) begin failures++; $display("FAIL oob_flag got=%b exp=1", oob_err); end
        checks++; if (write_count !== exp_count) begin failures++; $display("FAIL oob_write_count got=%0d exp=%0d", write_count, exp_count); end
        read_row(20, d, t);
        checks++; if (!t || d !== model_read(20)) begin failures++; $display("FAIL oob_alias_row got=%h exp=%h", d, model_read(20)); end
        read_row(500, d, t);
        checks++; if (!t || d !== 8'h00) begin failures++; $display("FAIL oob_read got=%h timing=%b exp=00", d, t); end
        $display("test_out_of_range oob=%b", oob_err);
    endtask

    task automatic test_collision();
        bit seen_done, ack_early, acked; logic [7:0] d; bit t;
        col_select = 1'b1; row_select = 10'd33; pixel_color = 8'h5A; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        seen_done = 0; ack_early = 0; acked = 0;
        for (int k = 0; k < 2000; k++) begin
            step();
            if (clear_done === 1'b1) seen_done = 1;
            if (return_sig === 1'b1) begin
                if (!seen_done) ack_early = 1;
                acked = 1;
                break;
            end
        end
        model_clear();
        if (acked) begin model_mem[33] = 8'h5A; exp_count = exp_count + 16'd1; end
        checks++; if (!acked || !seen_done || ack_early) begin failures++; $display("FAIL collision_order acked=%b done=%b early=%b exp=1/1/0", acked, seen_done, ack_early); end
        col_select = 1'b0;
        step();
        checks++; if (return_sig !== 1'b0) begin failures++; $display("FAIL collision_fall got=%b exp=0", return_sig); end
        read_row(33, d, t);
        checks++; if (!t || d !== 8'h5A) begin failures++; $display("FAIL collision_pixel got=%h exp=5a", d); end
        read_row(5, d, t);
        checks++; if (!t || d !== 8'h00) begin failures++; $display("FAIL collision_cleared got=%h exp=00", d); end
        $display("test_collision done=%b acked=%b", seen_done, acked);
    endtask

    task automatic test_clear_pending();
        int pulses; bit acked, ret_bad; logic [7:0] d; bit t;
        col_select = 1'b1; row_select = 10'd40; pixel_color = 8'h77;
        acked = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (return_sig === 1'b1) begin acked = 1; break; end
        end
        if (acked) begin model_mem[40] = 8'h77; exp_count = exp_count + 16'd1; end
        clear_req = 1'b1; step(); clear_req = 1'b0; step();
        clear_req = 1'b1; step(); clear_req = 1'b0;
        checks++; if (!acked || return_sig !== 1'b1) begin failures++; $display("FAIL pending_hold got=%b exp=1", return_sig); end
        col_select = 1'b0;
        pulses = 0; ret_bad = 0;
        for (int k = 0; k < 1600; k++) begin
            clear_req = (k == 100);
            step();
            if (clear_done === 1'b1) pulses++;
            if (k > 0 && return_sig !== 1'b0) ret_bad = 1;
        end
        clear_req = 1'b0;
        model_clear();
        checks++; if (pulses != 2) begin failures++; $display("FAIL pending_sweeps got=%0d exp=2", pulses); end
        checks++; if (ret_bad) begin failures++; $display("FAIL pending_return_sig high exp=0"); end
        read_row(40, d, t);
        checks++; if (!t || d !== 8'h00) begin failures++; $display("FAIL pending_cleared got=%h exp=00", d); end
        $display("test_clear_pending sweeps=%0d", pulses);
    endtask

    task automatic test_random_writes();
        int rl; bit h, f; int row; logic [7:0] c, d; bit t;
        for (int i = 0; i < 40; i++) begin
            row = ($urandom_range(0, 7) == 0) ? int'($urandom_range(480, 1023)) : int'($urandom_range(0, 479));
            c = 8'($urandom);
            plot(row, c, int'($urandom_range(0, 3)), rl, h, f);
            checks++; if (rl != 2 || !h || !f) begin failures++; $display("FAIL rand_handshake row=%0d rise=%0d held=%b fall=%b exp=2/1/1", row, rl, h, f); end
        end
        checks++; if (write_count !== exp_count) begin failures++; $display("FAIL rand_write_count got=%0d exp=%0d", write_count, exp_count); end
        checks++; if (oob_err !== exp_oob) begin failures++; $display("FAIL rand_oob got=%b exp=%b", oob_err, exp_oob); end
        for (int i = 0; i < 40; i++) begin
            row = int'($urandom_range(0, 519));
            read_row(row, d, t);
            checks++; if (!t || d !== model_read(row)) begin failures++; $display("FAIL rand_read row=%0d got=%h exp=%h timing=%b", row, d, model_read(row), t); end
        end
        $display("test_random_writes count=%0d", write_count);
    endtask

    task automatic test_back_to_back();
        int rows [8];
        for (int i = 0; i < 8; i++) rows[i] = int'($urandom_range(0, 479));
        rows[3] = 700;
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                checks++;
                if (vga_valid !== 1'b1 || vga_pixel !== model_read(rows[i-2])) begin
                    failures++;
                    $display("FAIL b2b_read idx=%0d row=%0d got=%h valid=%b exp=%h", i-2, rows[i-2], vga_pixel, vga_valid, model_read(rows[i-2]));
                end
            end
            vga_read_en = (i < 8);
            if (i < 8) vga_row = rows[i][ROW_W-1:0];
            step();
        end
        vga_read_en = 1'b0;
        checks++; if (vga_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_end got=%b exp=0", vga_valid); end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_handshake();
        int rl; bit h, f, acked, done_seen; logic [7:0] d; bit t;
        plot(60, 8'hC3, 0, rl, h, f);
        col_select = 1'b1; row_select = 10'd61; pixel_color = 8'h3E;
        acked = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (return_sig === 1'b1) begin acked = 1; break; end
        end
        if (acked) model_mem[61] = 8'h3E;
        clear_req = 1'b1; step(); clear_req = 1'b0;
        reset = 1'b1;
        step();
        checks++; if (return_sig !== 1'b0) begin failures++; $display("FAIL rst_mid_return_sig got=%b exp=0", return_sig); end
        checks++; if (write_count !== 16'd0 || oob_err !== 1'b0) begin failures++; $display("FAIL rst_mid_counters count=%0d oob=%b exp=0/0", write_count, oob_err); end
        reset = 1'b0; col_select = 1'b0;
        exp_count = 16'd0; exp_oob = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 700; k++) begin
            step();
            if (clear_done === 1'b1) done_seen = 1;
        end
        checks++; if (done_seen) begin failures++; $display("FAIL rst_mid_pending_dropped clear_done seen exp=none"); end
        read_row(60, d, t);
        checks++; if (!t || d !== 8'hC3) begin failures++; $display("FAIL rst_mid_row60 got=%h exp=c3", d); end
        read_row(61, d, t);
        checks++; if (!t || d !== model_read(61)) begin failures++; $display("FAIL rst_mid_row61 got=%h exp=%h", d, model_read(61)); end
        $display("test_reset_mid_handshake done");
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_handshake();
        test_slow_plotter();
        test_out_of_range();
        test_collision();
        test_clear_pending();
        test_random_writes();
        test_back_to_back();
        test_reset_mid_handshake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
